// File: rtl/interrupt_sched.sv
// -----------------------------------------------------------------------------
// interrupt_sched
//
// Takes the external-class interrupts (pin input, timer, doorbell) into the
// core. A request is only taken at a precise instruction boundary while
// MSR[EE] is set. The pipeline is then flushed for DRAIN_CYCLES cycles, and
// the PC/MSR captured at the boundary are written to SRR0/SRR1. Fetch is then
// redirected to the handler vector. The scheduler stays busy until the
// handler retires an rfi.
//
// Parameters
//   DRAIN_CYCLES  flush cycles before the redirect (1..15)
//   VEC_BASE      base address of the handler vectors
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   msr_ee              external interrupt enable
//   ext_input_req       pin interrupt request (level)
//   other_req           timer interrupt request (level)
//   doorbell_req        doorbell request (level)
//   insn_boundary       pipeline sits at a precise instruction boundary
//   cur_pc, cur_msr     next PC / current MSR, valid with insn_boundary
//   rfi                 return-from-interrupt retired (single cycle)
//   flush               pipeline flush, one per drain cycle
//   redirect            fetch redirect strobe
//   redirect_pc         handler address
//   srr_we, srr0, srr1  SRR write strobe and saved PC / MSR
//   clear_ee            clear MSR[EE] strobe
//   *_ack               single-cycle acknowledge of the serviced cause
//   busy                handler active
// -----------------------------------------------------------------------------
module interrupt_sched #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] VEC_BASE     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        msr_ee,
    input  logic        ext_input_req,
    input  logic        other_req,
    input  logic        doorbell_req,
    input  logic        insn_boundary,
    input  logic [31:0] cur_pc,
    input  logic [31:0] cur_msr,
    input  logic        rfi,
    output logic        flush,
    output logic        redirect,
    output logic [31:0] redirect_pc,
    output logic        srr_we,
    output logic [31:0] srr0,
    output logic [31:0] srr1,
    output logic        clear_ee,
    output logic        ext_input_ack,
    output logic        other_ack,
    output logic        doorbell_ack,
    output logic        busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT     = 3'd1,
        S_FLUSH    = 3'd2,
        S_REDIRECT = 3'd3,
        S_HANDLER  = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        C_NONE  = 2'd0,
        C_EXT   = 2'd1,
        C_OTHER = 2'd2,
        C_DB    = 2'd3
    } cause_t;

    // Vector offset of each cause relative to VEC_BASE.
    function automatic logic [31:0] vec_offset(input cause_t c);
        logic [31:0] off;
        case (c)
            C_EXT:   off = 32'h0000_0500;
            C_OTHER: off = 32'h0000_0900;
            C_DB:    off = 32'h0000_0A00;
            default: off = 32'h0000_0000;
        endcase
        return off;
    endfunction

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 32'd1);

    state_t     state_r;
    state_t     next_state_s;
    logic [3:0] cnt_r;
    cause_t     cause_r;
    cause_t     new_cause_s;
    logic       pending_s;
    logic       capture_s;
    logic       flush_s;
    logic       redirect_s;
    logic       busy_s;

    assign pending_s = msr_ee & (ext_input_req | other_req | doorbell_req);

    // Capture happens only on the edge that enters S_FLUSH from IDLE/WAIT.
    assign capture_s = (next_state_s == S_FLUSH) && (state_r != S_FLUSH);

    // Fixed-priority cause selection: ext_input > other > doorbell.
    always_comb begin
        new_cause_s = C_NONE;
        if (ext_input_req) begin
            new_cause_s = C_EXT;
        end else if (other_req) begin
            new_cause_s = C_OTHER;
        end else if (doorbell_req) begin
            new_cause_s = C_DB;
        end else begin
            new_cause_s = C_NONE;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (pending_s) begin
                    next_state_s = insn_boundary ? S_FLUSH : S_WAIT;
                end else begin
                    next_state_s = S_IDLE;
                end
            end
            S_WAIT: begin
                if (!pending_s) begin
                    next_state_s = S_IDLE;
                end else if (insn_boundary) begin
                    next_state_s = S_FLUSH;
                end else begin
                    next_state_s = S_WAIT;
                end
            end
            S_FLUSH: begin
                if (cnt_r == 4'd0) begin
                    next_state_s = S_REDIRECT;
                end else begin
                    next_state_s = S_FLUSH;
                end
            end
            S_REDIRECT: next_state_s = S_HANDLER;
            S_HANDLER: begin
                if (rfi) begin
                    next_state_s = S_IDLE;
                end else begin
                    next_state_s = S_HANDLER;
                end
            end
            default: next_state_s = S_IDLE;
        endcase
    end

    // Decode of the upcoming state; registered below so the strobes line up
    // with the state they describe and never glitch.
    always_comb begin
        flush_s    = 1'b0;
        redirect_s = 1'b0;
        busy_s     = 1'b0;
        case (next_state_s)
            S_IDLE, S_WAIT: begin
                flush_s    = 1'b0;
                redirect_s = 1'b0;
                busy_s     = 1'b0;
            end
            S_FLUSH:    flush_s    = 1'b1;
            S_REDIRECT: redirect_s = 1'b1;
            S_HANDLER:  busy_s     = 1'b1;
            default: begin
                flush_s    = 1'bx;
                redirect_s = 1'bx;
                busy_s     = 1'bx;
            end
        endcase
    end

    // State, drain counter, latched cause, SRR capture and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= S_IDLE;
            cnt_r         <= 4'd0;
            cause_r       <= C_NONE;
            flush         <= 1'b0;
            redirect      <= 1'b0;
            redirect_pc   <= 32'h0000_0000;
            srr_we        <= 1'b0;
            srr0          <= 32'h0000_0000;
            srr1          <= 32'h0000_0000;
            clear_ee      <= 1'b0;
            ext_input_ack <= 1'b0;
            other_ack     <= 1'b0;
            doorbell_ack  <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state_r       <= next_state_s;
            flush         <= flush_s;
            redirect      <= redirect_s;
            srr_we        <= redirect_s;
            clear_ee      <= redirect_s;
            ext_input_ack <= redirect_s & (cause_r == C_EXT);
            other_ack     <= redirect_s & (cause_r == C_OTHER);
            doorbell_ack  <= redirect_s & (cause_r == C_DB);
            busy          <= busy_s;
            if (capture_s) begin
                cause_r     <= new_cause_s;
                srr0        <= cur_pc;
                srr1        <= cur_msr;
                redirect_pc <= VEC_BASE + vec_offset(new_cause_s);
                cnt_r       <= DRAIN_LOAD;
            end else if ((state_r == S_FLUSH) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

endmodule

// File: tb/tb_interrupt_sched.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sched
//
// Two schedulers (DRAIN_CYCLES=3/VEC_BASE=0 and DRAIN_CYCLES=5/
// VEC_BASE=0xFFFF_FF00) share one stimulus. A timestamp-based reference model
// predicts every output each cycle. The model records the cycle an interrupt
// is taken, and derives flush, redirect and busy from the distance to that
// cycle. Directed scenarios run first, followed by random stimulus.
// -----------------------------------------------------------------------------
module tb_interrupt_sched;

    logic        clk = 1'b0;
    logic        reset, msr_ee, ext_input_req, other_req, doorbell_req;
    logic        insn_boundary, rfi;
    logic [31:0] cur_pc, cur_msr;

    logic        flush_0, redirect_0, srr_we_0, clear_ee_0, busy_0;
    logic        ext_ack_0, other_ack_0, db_ack_0;
    logic [31:0] redirect_pc_0, srr0_0, srr1_0;
    logic        flush_1, redirect_1, srr_we_1, clear_ee_1, busy_1;
    logic        ext_ack_1, other_ack_1, db_ack_1;
    logic [31:0] redirect_pc_1, srr0_1, srr1_1;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    interrupt_sched #(.DRAIN_CYCLES(3), .VEC_BASE(32'h0000_0000)) u0 (
        .clk(clk), .reset(reset), .msr_ee(msr_ee), .ext_input_req(ext_input_req),
        .other_req(other_req), .doorbell_req(doorbell_req), .insn_boundary(insn_boundary),
        .cur_pc(cur_pc), .cur_msr(cur_msr), .rfi(rfi), .flush(flush_0), .redirect(redirect_0),
        .redirect_pc(redirect_pc_0), .srr_we(srr_we_0), .srr0(srr0_0), .srr1(srr1_0),
        .clear_ee(clear_ee_0), .ext_input_ack(ext_ack_0), .other_ack(other_ack_0),
        .doorbell_ack(db_ack_0), .busy(busy_0)
    );

    interrupt_sched #(.DRAIN_CYCLES(5), .VEC_BASE(32'hFFFF_FF00)) u1 (
        .clk(clk), .reset(reset), .msr_ee(msr_ee), .ext_input_req(ext_input_req),
        .other_req(other_req), .doorbell_req(doorbell_req), .insn_boundary(insn_boundary),
        .cur_pc(cur_pc), .cur_msr(cur_msr), .rfi(rfi), .flush(flush_1), .redirect(redirect_1),
        .redirect_pc(redirect_pc_1), .srr_we(srr_we_1), .srr0(srr0_1), .srr1(srr1_1),
        .clear_ee(clear_ee_1), .ext_input_ack(ext_ack_1), .other_ack(other_ack_1),
        .doorbell_ack(db_ack_1), .busy(busy_1)
    );

    // Strobe vector: {flush, redirect, srr_we, clear_ee, ext_ack, other_ack, db_ack, busy}
    logic [7:0]  obs_str [2];
    logic [31:0] obs_pc  [2];
    logic [31:0] obs_s0  [2];
    logic [31:0] obs_s1  [2];
    assign obs_str[0] = {flush_0, redirect_0, srr_we_0, clear_ee_0, ext_ack_0, other_ack_0, db_ack_0, busy_0};
    assign obs_str[1] = {flush_1, redirect_1, srr_we_1, clear_ee_1, ext_ack_1, other_ack_1, db_ack_1, busy_1};
    assign obs_pc[0]  = redirect_pc_0;
    assign obs_pc[1]  = redirect_pc_1;
    assign obs_s0[0]  = srr0_0;
    assign obs_s0[1]  = srr0_1;
    assign obs_s1[0]  = srr1_0;
    assign obs_s1[1]  = srr1_1;

    // Reference model state, one slot per instance.
    int          drain  [2] = '{3, 5};
    logic [31:0] base   [2] = '{32'h0000_0000, 32'hFFFF_FF00};
    bit          active [2] = '{1'b0, 1'b0};
    int          t_take [2] = '{0, 0};
    int          mcause [2] = '{0, 0};
    logic [31:0] e_pc   [2] = '{32'h0, 32'h0};
    logic [31:0] e_s0   [2] = '{32'h0, 32'h0};
    logic [31:0] e_s1   [2] = '{32'h0, 32'h0};
    logic [7:0]  e_str  [2] = '{8'h0, 8'h0};
    int          cyc_n = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] offset_of(input int c);
        if (c == 1) return 32'h0000_0500;
        if (c == 2) return 32'h0000_0900;
        return 32'h0000_0A00;
    endfunction

    // Applies the inputs of cycle cyc_n to the model and predicts cycle cyc_n+1.
    task automatic model_update();
        int k;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                active[i] = 1'b0;
                e_pc[i]   = 32'h0;
                e_s0[i]   = 32'h0;
                e_s1[i]   = 32'h0;
            end else if (!active[i]) begin
                if (msr_ee && (ext_input_req || other_req || doorbell_req) && insn_boundary) begin
                    active[i] = 1'b1;
                    t_take[i] = cyc_n;
                    mcause[i] = ext_input_req ? 1 : (other_req ? 2 : 3);
                    e_s0[i]   = cur_pc;
                    e_s1[i]   = cur_msr;
                    e_pc[i]   = base[i] + offset_of(mcause[i]);
                end
            end else if ((cyc_n - t_take[i]) >= drain[i] + 2 && rfi) begin
                active[i] = 1'b0;
            end
            e_str[i] = 8'h00;
            if (active[i]) begin
                k = cyc_n + 1 - t_take[i];
                if (k <= drain[i]) begin
                    e_str[i][7] = 1'b1;
                end else if (k == drain[i] + 1) begin
                    e_str[i][6] = 1'b1;
                    e_str[i][5] = 1'b1;
                    e_str[i][4] = 1'b1;
                    e_str[i][4 - mcause[i]] = 1'b1;
                end else begin
                    e_str[i][0] = 1'b1;
                end
            end
        end
        cyc_n++;
    endtask

    // One clock: update model, cross the edge, compare on the falling edge.
    task automatic cyc();
        model_update();
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check_val($sformatf("u%0d.strobes@%0d", i, cyc_n), {24'h0, obs_str[i]}, {24'h0, e_str[i]});
            check_val($sformatf("u%0d.redirect_pc@%0d", i, cyc_n), obs_pc[i], e_pc[i]);
            check_val($sformatf("u%0d.srr0@%0d", i, cyc_n), obs_s0[i], e_s0[i]);
            check_val($sformatf("u%0d.srr1@%0d", i, cyc_n), obs_s1[i], e_s1[i]);
        end
    endtask

    initial begin
        reset = 1'b1; msr_ee = 1'b0; ext_input_req = 1'b0; other_req = 1'b0;
        doorbell_req = 1'b0; insn_boundary = 1'b0; rfi = 1'b0;
        cur_pc = 32'h0; cur_msr = 32'h0;
        cyc(); cyc();
        reset = 1'b0;
        cyc();
        check_val("reset.strobes", {24'h0, obs_str[0]}, 32'h0);
        check_val("reset.redirect_pc", redirect_pc_0, 32'h0);

        // Basic take of the pin interrupt.
        msr_ee = 1'b1; ext_input_req = 1'b1; insn_boundary = 1'b1;
        cur_pc = 32'h0000_1234; cur_msr = 32'h0000_8000;
        cyc();
        ext_input_req = 1'b0; insn_boundary = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            check_val($sformatf("basic.flush%0d", i), {31'h0, flush_0}, 32'h1);
            cyc();
        end
        check_val("basic.redirect", {31'h0, redirect_0}, 32'h1);
        check_val("basic.redirect_pc", redirect_pc_0, 32'h0000_0500);
        check_val("basic.srr0", srr0_0, 32'h0000_1234);
        check_val("basic.srr1", srr1_0, 32'h0000_8000);
        check_val("basic.ext_ack", {31'h0, ext_ack_0}, 32'h1);
        check_val("basic.clear_ee", {31'h0, clear_ee_0}, 32'h1);
        cyc();
        check_val("basic.busy", {31'h0, busy_0}, 32'h1);
        reset = 1'b1; cyc(); reset = 1'b0;

        // Priority: all three, then other, then doorbell after each rfi.
        ext_input_req = 1'b1; other_req = 1'b1; doorbell_req = 1'b1; insn_boundary = 1'b1;
        cyc();
        insn_boundary = 1'b0;
        repeat (3) cyc();
        check_val("prio.ext_ack", {31'h0, ext_ack_0}, 32'h1);
        check_val("prio.other_ack_low", {31'h0, other_ack_0}, 32'h0);
        repeat (4) cyc();
        ext_input_req = 1'b0; rfi = 1'b1; cyc(); rfi = 1'b0;
        insn_boundary = 1'b1; cyc(); insn_boundary = 1'b0;
        repeat (3) cyc();
        check_val("prio.other_ack", {31'h0, other_ack_0}, 32'h1);
        check_val("prio.ext_ack_low", {31'h0, ext_ack_0}, 32'h0);
        check_val("prio.other_pc", redirect_pc_0, 32'h0000_0900);
        repeat (4) cyc();
        other_req = 1'b0; rfi = 1'b1; cyc(); rfi = 1'b0;
        insn_boundary = 1'b1; cyc(); insn_boundary = 1'b0;
        repeat (3) cyc();
        check_val("prio.db_ack", {31'h0, db_ack_0}, 32'h1);
        check_val("prio.db_pc", redirect_pc_0, 32'h0000_0A00);
        repeat (2) cyc();
        check_val("wrap.db_ack", {31'h0, db_ack_1}, 32'h1);
        check_val("wrap.pc", redirect_pc_1, 32'h0000_0900);
        doorbell_req = 1'b0;
        repeat (2) cyc();
        rfi = 1'b1; cyc(); rfi = 1'b0;

        // Wait then cancel; wait then take at a late boundary.
        other_req = 1'b1;
        repeat (5) cyc();
        other_req = 1'b0;
        cyc();
        repeat (3) begin
            check_val("cancel.flush", {31'h0, flush_0}, 32'h0);
            check_val("cancel.ack", {31'h0, other_ack_0}, 32'h0);
            cyc();
        end
        other_req = 1'b1;
        repeat (5) cyc();
        insn_boundary = 1'b1; cyc();
        check_val("wait.flush", {31'h0, flush_0}, 32'h1);
        insn_boundary = 1'b0; other_req = 1'b0;
        repeat (8) cyc();
        rfi = 1'b1; cyc(); rfi = 1'b0;

        // Masking: no activity with EE clear; rfi in idle ignored.
        msr_ee = 1'b0; ext_input_req = 1'b1; other_req = 1'b1; doorbell_req = 1'b1;
        repeat (10) begin
            insn_boundary = 1'($urandom_range(0, 1));
            rfi = 1'($urandom_range(0, 1));
            cyc();
            check_val("mask.busy", {31'h0, busy_0}, 32'h0);
            check_val("mask.flush", {31'h0, flush_0}, 32'h0);
        end
        ext_input_req = 1'b0; other_req = 1'b0; doorbell_req = 1'b0; rfi = 1'b0;
        insn_boundary = 1'b0;

        // Reset during the second flush cycle.
        msr_ee = 1'b1; ext_input_req = 1'b1; insn_boundary = 1'b1; cur_pc = 32'hCAFE_0000;
        cyc();
        ext_input_req = 1'b0; insn_boundary = 1'b0;
        cyc();
        reset = 1'b1; cyc(); reset = 1'b0;
        check_val("rstmid.strobes", {24'h0, obs_str[0]}, 32'h0);
        check_val("rstmid.srr0", srr0_0, 32'h0);
        repeat (3) begin
            cyc();
            check_val("rstmid.no_redirect", {31'h0, redirect_0}, 32'h0);
        end

        // Random stimulus against the model.
        repeat (3000) begin
            reset         = ($urandom_range(0, 199) == 0);
            msr_ee        = ($urandom_range(0, 7) != 0);
            ext_input_req = ($urandom_range(0, 3) == 0);
            other_req     = ($urandom_range(0, 3) == 0);
            doorbell_req  = ($urandom_range(0, 3) == 0);
            insn_boundary = 1'($urandom_range(0, 1));
            rfi           = ($urandom_range(0, 5) == 0);
            cur_pc        = $urandom;
            cur_msr       = $urandom;
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
